// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: glyph geometry, colour and counter widths,
// and the packed bundle of timing signals carried alongside each pixel.
package vga_pkg;

    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;
    localparam int RGB_W  = 12;
    localparam int CNT_W  = 11;

    // Timing bundle, 2*CNT_W + 4 = 26 bits.
    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             hblnk;
        logic             vsync;
        logic             vblnk;
    } timing_t;

endpackage

// File: rtl/delay.sv
// Generic shift-register delay line with synchronous active-high reset.
// Ports: clk, rst, din[WIDTH] -> dout[WIDTH] delayed by CLK_DEL clock cycles.
module delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [CLK_DEL];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CLK_DEL; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_text_box.sv
// Character-text overlay: draws a ROWS x COLS grid of 8x16 glyphs scaled by
// 2^SCALE_LOG2 at a per-frame latched position, with optional transparent
// background and frame-counted blinking.
// Ports:
//   pclk, rst                       pixel clock, synchronous active-high reset
//   hcount/vcount/hsync/hblnk/
//   vsync/vblnk/rgb _in             upstream pixel stream
//   pos_x, pos_y                    box top-left, latched on vblnk rise
//   color_fg, color_bg              glyph and background colours
//   transparent                     background pixels pass rgb_in through
//   blink_en                        box alternates visible/hidden
//   char_pixels                     glyph row from ROM (bit 7 = leftmost)
//   *_out                           stream delayed by 2 pclk
//   char_xy, char_line              {row, col} and glyph line to the ROM
module draw_text_box
    import vga_pkg::*;
#(
    parameter int COL_BITS     = 4,
    parameter int ROW_BITS     = 4,
    parameter int SCALE_LOG2   = 0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                         pclk,
    input  logic                         rst,
    input  logic [CNT_W-1:0]             hcount_in,
    input  logic [CNT_W-1:0]             vcount_in,
    input  logic                         hsync_in,
    input  logic                         hblnk_in,
    input  logic                         vsync_in,
    input  logic                         vblnk_in,
    input  logic [RGB_W-1:0]             rgb_in,
    input  logic [CNT_W-1:0]             pos_x,
    input  logic [CNT_W-1:0]             pos_y,
    input  logic [RGB_W-1:0]             color_fg,
    input  logic [RGB_W-1:0]             color_bg,
    input  logic                         transparent,
    input  logic                         blink_en,
    input  logic [CHAR_W-1:0]            char_pixels,
    output logic [CNT_W-1:0]             hcount_out,
    output logic [CNT_W-1:0]             vcount_out,
    output logic                         hsync_out,
    output logic                         hblnk_out,
    output logic                         vsync_out,
    output logic                         vblnk_out,
    output logic [RGB_W-1:0]             rgb_out,
    output logic [ROW_BITS+COL_BITS-1:0] char_xy,
    output logic [3:0]                   char_line
);

    localparam int COLS  = 1 << COL_BITS;
    localparam int ROWS  = 1 << ROW_BITS;
    localparam int SCALE = 1 << SCALE_LOG2;

    // One extra bit so boxes running past 2047 clip instead of wrapping.
    localparam int EXT_W = CNT_W + 1;
    localparam logic [EXT_W-1:0] BOX_W = EXT_W'(COLS * CHAR_W * SCALE);
    localparam logic [EXT_W-1:0] BOX_H = EXT_W'(ROWS * CHAR_H * SCALE);

    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    // Per-frame state
    logic [CNT_W-1:0] px;
    logic [CNT_W-1:0] py;
    logic             vblnk_prev;
    logic [FC_W-1:0]  frame_cnt;
    logic             visible;
    logic             vblnk_rise;

    // Geometry
    logic [EXT_W-1:0] dx;
    logic [EXT_W-1:0] dy;
    logic [EXT_W-1:0] u;
    logic [EXT_W-1:0] v;
    logic             in_x;
    logic             in_y;
    logic             in_box;
    logic             unused_bits;

    // Stage 1
    logic             draw_d1;
    logic [2:0]       bit_d1;
    logic [RGB_W-1:0] rgb_d1;
    logic             blank_d1;

    // Timing pipeline
    timing_t          timing_in;
    timing_t          timing_d2;

    assign vblnk_rise = vblnk_in & ~vblnk_prev;

    // Position latch and blink counter, both advanced on the vblnk rise.
    always_ff @(posedge pclk) begin
        if (rst) begin
            px         <= '0;
            py         <= '0;
            vblnk_prev <= 1'b0;
            frame_cnt  <= '0;
            visible    <= 1'b1;
        end else begin
            vblnk_prev <= vblnk_in;
            if (vblnk_rise) begin
                px <= pos_x;
                py <= pos_y;
                if (frame_cnt == FC_LAST) begin
                    frame_cnt <= '0;
                    visible   <= ~visible;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    assign dx = {1'b0, hcount_in} - {1'b0, px};
    assign dy = {1'b0, vcount_in} - {1'b0, py};

    assign in_x   = (hcount_in >= px) && (dx < BOX_W);
    assign in_y   = (vcount_in >= py) && (dy < BOX_H);
    assign in_box = in_x && in_y;

    // Unscaled glyph-space coordinates.
    assign u = dx >> SCALE_LOG2;
    assign v = dy >> SCALE_LOG2;

    assign unused_bits = ^{u[EXT_W-1:COL_BITS+3], v[EXT_W-1:ROW_BITS+4]};

    // Stage 1: ROM address plus everything stage 2 needs alongside the glyph.
    always_ff @(posedge pclk) begin
        if (rst) begin
            char_xy   <= '0;
            char_line <= '0;
            draw_d1   <= 1'b0;
            bit_d1    <= '0;
            rgb_d1    <= '0;
            blank_d1  <= 1'b0;
        end else begin
            char_xy   <= {v[ROW_BITS+3:4], u[COL_BITS+2:3]};
            char_line <= v[3:0];
            draw_d1   <= in_box & (visible | ~blink_en);
            bit_d1    <= 3'd7 - u[2:0];
            rgb_d1    <= rgb_in;
            blank_d1  <= hblnk_in | vblnk_in;
        end
    end

    // Stage 2: compose against the glyph row returned for the stage-1 address.
    always_ff @(posedge pclk) begin
        if (rst) begin
            rgb_out <= '0;
        end else if (blank_d1) begin
            rgb_out <= '0;
        end else if (!draw_d1) begin
            rgb_out <= rgb_d1;
        end else if (char_pixels[bit_d1]) begin
            rgb_out <= color_fg;
        end else if (transparent) begin
            rgb_out <= rgb_d1;
        end else begin
            rgb_out <= color_bg;
        end
    end

    assign timing_in = '{
        hcount: hcount_in,
        vcount: vcount_in,
        hsync:  hsync_in,
        hblnk:  hblnk_in,
        vsync:  vsync_in,
        vblnk:  vblnk_in
    };

    delay #(
        .WIDTH   ($bits(timing_t)),
        .CLK_DEL (2)
    ) u_timing_delay (
        .clk  (pclk),
        .rst  (rst),
        .din  (timing_in),
        .dout (timing_d2)
    );

    assign hcount_out = timing_d2.hcount;
    assign vcount_out = timing_d2.vcount;
    assign hsync_out  = timing_d2.hsync;
    assign hblnk_out  = timing_d2.hblnk;
    assign vsync_out  = timing_d2.vsync;
    assign vblnk_out  = timing_d2.vblnk;

endmodule
